// File: rtl/gt_2_sweep_checker.sv
// rtl/gt_2_sweep_checker.sv - exhaustive sweep tester for a WIDTH-bit a>b comparator
// Drives every {b,a} vector, samples agtb at the end of each dwell, tallies and latches mismatches.
module gt_2_sweep_checker #(
    parameter int WIDTH = 2,
    parameter int DWELL = 200
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    input  logic               agtb,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_cnt,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int IW = 2 * WIDTH;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};
    localparam logic [IW:0]   ERR_MAX  = {1'b1, {IW{1'b0}}};
    localparam logic [DW-1:0] DLAST    = DW'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]    r_idx;
    logic [DW-1:0]    r_dcnt;
    logic [IW:0]      r_err;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic             r_have_fail;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_sample;
    logic             w_golden;
    logic             w_mis;
    logic             w_err_inc;
    logic [IW:0]      w_err_next;
    logic             w_launch;
    logic             w_last;

    // agtb is only trusted on the final dwell cycle; earlier cycles are settling time
    assign w_sample   = (r_state == S_DRIVE) && (r_dcnt == DLAST);
    assign w_golden   = r_idx[WIDTH-1:0] > r_idx[IW-1:WIDTH];
    assign w_mis      = w_sample && (agtb != w_golden);
    assign w_err_inc  = w_mis && (r_err != ERR_MAX);
    assign w_err_next = r_err + {{IW{1'b0}}, w_err_inc};
    assign w_launch   = start && (r_state != S_DRIVE);
    assign w_last     = w_sample && (r_idx == LAST_IDX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_DRIVE;
            S_DRIVE: if (w_last) w_next = S_DONE;
            S_DONE:  if (start)  w_next = S_DRIVE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_dcnt      <= '0;
            r_err       <= '0;
            r_fail_a    <= '0;
            r_fail_b    <= '0;
            r_have_fail <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else if (w_launch) begin
            r_idx       <= '0;
            r_dcnt      <= '0;
            r_err       <= '0;
            r_fail_a    <= '0;
            r_fail_b    <= '0;
            r_have_fail <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else if (r_state == S_DRIVE) begin
            r_err <= w_err_next;
            if (w_mis && !r_have_fail) begin
                r_fail_a    <= r_idx[WIDTH-1:0];
                r_fail_b    <= r_idx[IW-1:WIDTH];
                r_have_fail <= 1'b1;
            end
            if (w_sample) begin
                if (w_last) begin
                    // a/b keep the last vector so the board shows where the sweep ended
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_pass <= (w_err_next == '0);
                end else begin
                    r_idx  <= r_idx + 1'b1;
                    r_dcnt <= '0;
                end
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    assign a       = r_idx[WIDTH-1:0];
    assign b       = r_idx[IW-1:WIDTH];
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err;
    assign fail_a  = r_fail_a;
    assign fail_b  = r_fail_b;

endmodule

// File: tb/tb_gt_2_sweep_checker.sv
// tb/tb_gt_2_sweep_checker.sv - self-checking bench for gt_2_sweep_checker (WIDTH=2, DWELL=4)
module tb_gt_2_sweep_checker;

    localparam int WIDTH = 2;
    localparam int DWELL = 4;
    localparam int NVEC  = 16;
    localparam int SWEEP = NVEC * DWELL;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             agtb;
    logic             busy;
    logic             done;
    logic             pass;
    logic [2*WIDTH:0] err_cnt;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;

    int mode;
    int checks;
    int errors;

    typedef struct {
        int mode;
        int err;
        int fa;
        int fb;
        int pass;
    } exp_t;

    exp_t vec[4];
    exp_t sb[$];

    gt_2_sweep_checker #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .agtb    (agtb),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .fail_a  (fail_a),
        .fail_b  (fail_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator models: 0 correct, 1 stuck-at-0, 2 inverted, 3 wrong only at a=3,b=2
    always_comb begin
        agtb = 1'b0;
        case (mode)
            0: agtb = (a > b);
            1: agtb = 1'b0;
            2: agtb = !(a > b);
            3: agtb = (a == 2'd3 && b == 2'd2) ? 1'b0 : (a > b);
            default: agtb = (a > b);
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic sweep(input int m, input bit check_order, input int repulse_at,
                         output int cycles);
        exp_t e;
        mode = m;
        e = vec[m];
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(e);
        chk("start_busy", int'(busy), 1);
        chk("start_done_drop", int'(done), 0);
        chk("start_err_clear", int'(err_cnt), 0);
        chk("start_pass_low", int'(pass), 0);
        cycles = 0;
        while (!done && cycles < 4 * SWEEP) begin
            if (check_order) chk("vector_order", int'({b, a}), cycles / DWELL);
            start = (cycles == repulse_at);
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic check_result();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("err_cnt", int'(err_cnt), e.err);
        chk("fail_a", int'(fail_a), e.fa);
        chk("fail_b", int'(fail_b), e.fb);
        chk("pass", int'(pass), e.pass);
        chk("end_busy", int'(busy), 0);
        chk("end_a_last", int'(a), 3);
        chk("end_b_last", int'(b), 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        checks  = 0;
        errors  = 0;
        mode    = 0;
        start   = 1'b0;
        reset_n = 1'b0;
        vec[0] = '{mode: 0, err: 0,  fa: 0, fb: 0, pass: 1};
        vec[1] = '{mode: 1, err: 6,  fa: 1, fb: 0, pass: 0};
        vec[2] = '{mode: 2, err: 16, fa: 0, fb: 0, pass: 0};
        vec[3] = '{mode: 3, err: 1,  fa: 3, fb: 2, pass: 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", int'(a), 0);
        chk("rst_b", int'(b), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_fail_a", int'(fail_a), 0);
        chk("rst_fail_b", int'(fail_b), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_start_busy", int'(busy), 0);

        for (int i = 0; i < 4; i++) begin
            sweep(vec[i].mode, (i == 0), -1, cyc);
            chk("sweep_len", cyc, SWEEP);
            check_result();
        end

        sweep(1, 1'b0, 20, cyc);
        chk("repulse_sweep_len", cyc, SWEEP);
        check_result();
        repeat (5) @(posedge clk);
        #1;
        chk("done_hold", int'(done), 1);
        chk("done_hold_err", int'(err_cnt), 6);
        sweep(0, 1'b0, -1, cyc);
        chk("restart_sweep_len", cyc, SWEEP);
        check_result();

        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("pre_reset_err_nonzero", int'(err_cnt != 0), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_a", int'(a), 0);
        chk("async_rst_b", int'(b), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_err", int'(err_cnt), 0);
        chk("async_rst_fail_a", int'(fail_a), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle_busy", int'(busy), 0);
        chk("post_rst_idle_done", int'(done), 0);
        chk("post_rst_idle_a", int'(a), 0);
        chk("post_rst_idle_b", int'(b), 0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
